pipe_skid_stage: RTL and testbench

Parametrised elastic pipeline-stage register that replaces the fixed stall/flush stage registers between pipeline stages (fetch→decode, decode→execute, …). It carries an arbitrary-width payload with a valid/ready handshake and a one-entry skid buffer, so `in_ready` is fully registered while full throughput is kept. Flush inserts a bubble with a programmable payload. Saturating counters record back-pressure cycles and flushed beats for performance debug.

---
 rtl/pipe_skid_stage.sv | 151 +++++++++++++++
 tb/tb_pipe_skid_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Purpose  : Elastic pipeline-stage register with a one-entry skid buffer.
//            Carries a DATA_W payload over a valid/ready handshake with a
//            fully registered in_ready at full throughput. Flush squashes
//            every held and incoming beat and drives FLUSH_VAL on out_data.
//            Saturating counters track stalled cycles and flushed beats.
// Ports    : clk, rst (async, active-high)
//            flush                          - synchronous squash
//            in_valid / in_ready / in_data  - upstream handshake
//            out_valid / out_ready / out_data - downstream handshake
//            stall_cnt                      - cycles with out_valid && !out_ready
//            flush_cnt                      - valid beats discarded by flush
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int               c_sum_w   = CNT_W + 1;
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic              out_valid_q,  out_valid_d;
    logic [DATA_W-1:0] out_data_q,   out_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              in_ready_q,   in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q,  flush_cnt_d;

    logic              w_acc;
    logic              w_emt;
    logic [1:0]        w_held;
    logic [1:0]        w_flush_add;
    logic [c_sum_w-1:0] w_stall_sum;
    logic [c_sum_w-1:0] w_flush_sum;

    assign w_acc = in_valid && in_ready_q;
    assign w_emt = out_valid_q && out_ready;

    // Beats lost to a flush: held entries not emitted this cycle plus any
    // beat accepted in the same cycle. Never exceeds 2 because an accept
    // cannot happen while both entries are held.
    assign w_held      = {1'b0, out_valid_q} + {1'b0, skid_valid_q};
    assign w_flush_add = w_held - {1'b0, w_emt} + {1'b0, w_acc};

    assign w_stall_sum = {1'b0, stall_cnt_q} + c_sum_w'(out_valid_q && !out_ready);
    assign w_flush_sum = {1'b0, flush_cnt_q} + c_sum_w'(w_flush_add);

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;

        if (w_stall_sum > {1'b0, c_cnt_max}) begin
            stall_cnt_d = c_cnt_max;
        end else begin
            stall_cnt_d = w_stall_sum[CNT_W-1:0];
        end

        if (flush) begin
            out_valid_d  = 1'b0;
            out_data_d   = FLUSH_VAL;
            skid_valid_d = 1'b0;
            if (w_flush_sum > {1'b0, c_cnt_max}) begin
                flush_cnt_d = c_cnt_max;
            end else begin
                flush_cnt_d = w_flush_sum[CNT_W-1:0];
            end
        end else begin
            // State is encoded by {main valid, skid valid}.
            case ({out_valid_q, skid_valid_q})
                2'b00: begin
                    if (w_acc) begin
                        out_valid_d = 1'b1;
                        out_data_d  = in_data;
                    end
                end
                2'b10: begin
                    if (w_acc && w_emt) begin
                        out_data_d = in_data;
                    end else if (w_acc) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data;
                    end else if (w_emt) begin
                        // Data is left as-is; only the valid bit drops.
                        out_valid_d = 1'b0;
                    end
                end
                2'b11: begin
                    if (w_emt) begin
                        out_data_d   = skid_data_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    // Skid-only occupancy cannot be reached; hold state.
                end
            endcase
        end

        // Registered ready: deassert exactly when the next state is FULL.
        in_ready_d = !(out_valid_d && skid_valid_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= FLUSH_VAL;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_stage
// Purpose  : Self-checking bench for pipe_skid_stage. Two instances share the
//            same stimulus: one with 16-bit counters and one with 2-bit
//            counters so saturation is reached quickly. Outputs are compared
//            against a queue-based model of the stage's occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

    localparam int               c_dw    = 16;
    localparam logic [c_dw-1:0]  c_fv    = 16'hF00D;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [c_dw-1:0] in_data = '0;

    logic            in_ready_a,  in_ready_b;
    logic            out_valid_a, out_valid_b;
    logic [c_dw-1:0] out_data_a,  out_data_b;
    logic [15:0]     stall_a,     flush_a;
    logic [1:0]      stall_b,     flush_b;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: FIFO of held beats (at most 2), last presented data.
    logic [c_dw-1:0] mq[$];
    logic [c_dw-1:0] m_last;
    bit              m_ready;
    int              m_stall;
    int              m_flush;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(c_dw), .FLUSH_VAL(c_fv), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .stall_cnt(stall_a), .flush_cnt(flush_a)
    );

    pipe_skid_stage #(.DATA_W(c_dw), .FLUSH_VAL(c_fv), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .stall_cnt(stall_b), .flush_cnt(flush_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? 64'(mx) : 64'(v);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_last  = c_fv;
        m_ready = 1'b1;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Applies the stage's rules to the inputs present before the coming edge.
    task automatic model_step();
        bit acc, emt;
        acc = in_valid && m_ready;
        emt = (mq.size() > 0) && out_ready;
        if (mq.size() > 0 && !out_ready) m_stall++;
        if (flush) begin
            m_flush += mq.size() - (emt ? 1 : 0) + (acc ? 1 : 0);
            mq.delete();
            m_last = c_fv;
        end else begin
            if (emt) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
            if (mq.size() > 0) m_last = mq[0];
        end
        m_ready = (mq.size() < 2);
    endtask

    task automatic check_all();
        check("out_valid", 64'(out_valid_a), 64'(mq.size() > 0));
        check("out_data",  64'(out_data_a),  64'(m_last));
        check("in_ready",  64'(in_ready_a),  64'(m_ready));
        check("stall_cnt", 64'(stall_a),     sat(m_stall, 16));
        check("flush_cnt", 64'(flush_a),     sat(m_flush, 16));
        check("stall_cnt_w2", 64'(stall_b),  sat(m_stall, 2));
        check("flush_cnt_w2", 64'(flush_b),  sat(m_flush, 2));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input logic [c_dw-1:0] d, input bit rdy, input bit fl);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all();
    endtask

    initial begin
        model_reset();

        // Reset values
        do_reset();
        check("rst_out_data", 64'(out_data_a), 64'(c_fv));
        check("rst_in_ready", 64'(in_ready_a), 64'd1);

        // Streaming at full rate
        drive(1'b1, 16'h0011, 1'b1, 1'b0); cycle();
        check("stream_0", 64'(out_data_a), 64'h11);
        drive(1'b1, 16'h0022, 1'b1, 1'b0); cycle();
        check("stream_1", 64'(out_data_a), 64'h22);
        drive(1'b1, 16'h0033, 1'b1, 1'b0); cycle();
        check("stream_2", 64'(out_data_a), 64'h33);
        check("stream_rdy", 64'(in_ready_a), 64'd1);
        check("stream_stall", 64'(stall_a), 64'd0);
        drive(1'b0, '0, 1'b1, 1'b0); cycle();

        // Back-pressure: A3 is held upstream until accepted
        do_reset();
        drive(1'b1, 16'h00A1, 1'b0, 1'b0); cycle();
        drive(1'b1, 16'h00A2, 1'b0, 1'b0); cycle();
        check("bp_full_rdy", 64'(in_ready_a), 64'd0);
        drive(1'b1, 16'h00A3, 1'b0, 1'b0);
        repeat (3) begin
            cycle();
            check("bp_hold", 64'(out_data_a), 64'hA1);
        end
        check("bp_stall4", 64'(stall_a), 64'd4);
        drive(1'b1, 16'h00A3, 1'b1, 1'b0); cycle();
        check("bp_order_1", 64'(out_data_a), 64'hA2);
        check("bp_recover", 64'(in_ready_a), 64'd1);
        cycle();
        check("bp_order_2", 64'(out_data_a), 64'hA3);
        drive(1'b0, '0, 1'b1, 1'b0); cycle();

        // Flush in FULL with a beat offered and downstream stalled
        do_reset();
        drive(1'b1, 16'h00B1, 1'b0, 1'b0); cycle();
        drive(1'b1, 16'h00B2, 1'b0, 1'b0); cycle();
        drive(1'b1, 16'h00B3, 1'b0, 1'b1); cycle();
        check("fl_full_valid", 64'(out_valid_a), 64'd0);
        check("fl_full_data",  64'(out_data_a),  64'(c_fv));
        check("fl_full_rdy",   64'(in_ready_a),  64'd1);
        check("fl_full_cnt",   64'(flush_a),     64'd2);
        drive(1'b1, 16'h00B4, 1'b0, 1'b0); cycle();
        check("fl_after_acc", 64'(out_data_a), 64'hB4);

        // Flush in ONE: main beat delivered, incoming dropped
        do_reset();
        drive(1'b1, 16'h00C1, 1'b0, 1'b0); cycle();
        drive(1'b1, 16'h00C2, 1'b1, 1'b1);
        #1;
        check("fl_one_deliver", 64'(out_valid_a && out_data_a == 16'h00C1), 64'd1);
        cycle();
        check("fl_one_cnt", 64'(flush_a), 64'd1);
        check("fl_one_valid", 64'(out_valid_a), 64'd0);

        // Asynchronous reset in the middle of a FULL cycle
        drive(1'b1, 16'h00D1, 1'b0, 1'b0); cycle();
        drive(1'b1, 16'h00D2, 1'b0, 1'b0); cycle();
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid_a), 64'd0);
        check("arst_data",  64'(out_data_a),  64'(c_fv));
        check("arst_rdy",   64'(in_ready_a),  64'd1);
        check("arst_cnts",  64'({stall_a, flush_a}), 64'd0);
        do_reset();
        // First accept right after reset release
        drive(1'b1, 16'h00E1, 1'b1, 1'b0); cycle();
        check("arst_first_acc", 64'(out_data_a), 64'hE1);

        // Saturation on the 2-bit counter instance
        do_reset();
        drive(1'b1, 16'h00F1, 1'b0, 1'b0); cycle();
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (6) cycle();
        check("sat_stall_w2", 64'(stall_b), 64'd3);
        cycle();
        check("sat_stall_hold", 64'(stall_b), 64'd3);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
